wb_stage: RTL and testbench
===========================

# wb_stage

Registered, parametrised writeback stage for the STRV32I datapath. It replaces the purely combinational writeback select with a one-cycle pipeline register and a 2-entry skid buffer under valid/ready flow control. It performs load-data alignment and sign/zero extension, adds a CSR read source, and flags misaligned loads. It sits between the memory-access stage and the integer register-file write port, and keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width (32 or 64)
- `RA_W`, 5, register address width
- `CNT_W`, 64, retired-instruction counter width

Ports:
- `clk_in`  in  1  clock, all state on rising edge
- `rst_n_in`  in  1  asynchronous active-low reset
- `valid_in`  in  1  upstream entry valid
- `ready_out`  out  1  stage can accept; equals NOT skid-full (registered)
- `wb_mux_sel_in`  in  3  000 alu, 001 load, 010 imm, 011 iadder, 100 csr, 101 pc+4, others alu
- `alu_result_in`, `imm_in`, `iadder_in`, `pc_plus_4_in`, `csr_data_in`  in  XLEN  source operands
- `load_data_in`  in  XLEN  raw memory word (naturally aligned container)
- `load_size_in`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `load_unsigned_in`  in  1  1 = zero-extend, 0 = sign-extend
- `addr_lsb_in`  in  2  low address bits of the load
- `rd_addr_in`  in  RA_W  destination register
- `rf_wr_en_in`  in  1  instruction writes rd
- `rf_ready_in`  in  1  register-file port accepts the output entry
- `valid_out`  out  1  output entry valid
- `rf_wr_en_out`  out  1  `valid_out` AND stored wr_en AND rd != 0 AND NOT misalign
- `rd_addr_out`  out  RA_W  destination of output entry
- `rd_data_out`  out  XLEN  selected and aligned writeback data
- `misalign_err_out`  out  1  one-cycle pulse when a misaligned load entry retires
- `instret_out`  out  CNT_W  count of retired entries

## Operation
- Accept when `valid_in & ready_out`. Data is selected and aligned combinationally before capture, so stored entries hold final data.
- Load alignment uses a shift of `addr_lsb_in*8`, then extracts byte or half and extends per `load_unsigned_in`. Word loads pass through unchanged.
- Misaligned cases are half with `addr_lsb_in[0]=1`, and word with `addr_lsb_in!=0`. Only `wb_mux_sel_in==001` is checked. For a misaligned entry the data is forced to 0 and the misalign bit is stored.
- Storage is an output register (OR) plus one skid register (SK).
- Retire is `valid_out & rf_ready_in`.
- On accept with OR empty, or OR retiring and SK empty, the entry goes to OR.
- On accept with OR full and not retiring, the entry goes to SK, and `ready_out` drops the next cycle.
- On retire with SK full, SK moves to OR, SK empties, and `ready_out` rises the next cycle.
- Simultaneous accept and retire with SK full is impossible because `ready_out` is 0.
- `instret_out` increments by 1 per retire, whether or not rd is written, including misaligned entries. It wraps modulo 2^CNT_W.
- `misalign_err_out` is 1 in the cycle where a retiring OR entry has its misalign bit set. It is combinational from OR state and `rf_ready_in`.
- For XLEN=64, a word load sign/zero-extends 32 bits and size 11 is a doubleword. The misalign rule for size 11 with XLEN=64 is `addr_lsb_in!=0`, with the 3rd LSB ignored.

## Timing
- Reset (async assert, sync deassert expected externally) clears OR and SK valid, all stored data, and `instret_out`.
- Output values during reset: `valid_out`=0, `rf_wr_en_out`=0, `rd_addr_out`=0, `rd_data_out`=0, `misalign_err_out`=0, `instret_out`=0, `ready_out`=1.
- Latency is 1 cycle: an entry accepted at edge N drives `valid_out` after edge N. Throughput is 1 entry per cycle while `rf_ready_in` is held high.
- `valid_out` and entry fields hold stable until retire. Upstream must hold inputs stable while `valid_in & !ready_out`.
- Reset mid-operation drops all buffered entries and does not count them.

## Test plan
- Single ALU op: sel=000, alu=0x0000_1234, rd=5, rf_ready_in=1. Next cycle `valid_out`=1, `rd_data_out`=0x1234, `rf_wr_en_out`=1, and `instret_out` goes 0→1.
- Signed byte load: word=0x80FF_7F01, lsb=3, size=00, unsigned=0 → data 0xFFFF_FF80. The same entry with unsigned=1 → 0x0000_0080.
- Misaligned half: lsb=1, size=01, rd=7 → `rd_data_out`=0, `rf_wr_en_out`=0, `misalign_err_out` pulses once, and `instret_out` increments.
- Backpressure: stream entries A, B, C every cycle, with `rf_ready_in`=0 from cycle 1.
  - A holds in OR, B goes to SK, and `ready_out`=0.
  - Raising `rf_ready_in` retires A, then B, then C, in order with no loss or duplicate.
- rd=0 write: sel=101, pc+4=0x104, rd=0 → `valid_out`=1, `rf_wr_en_out`=0, and `instret_out` increments.
- Reset mid-stall: with OR and SK full, pulse `rst_n_in` low between edges → all outputs immediately at reset values, and `ready_out`=1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: selects and aligns the result, then holds it in an output register with a one-entry skid buffer.
// Latency is 1 cycle. ready_out is registered and drops only while the skid entry is occupied.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [2:0]        wb_mux_sel_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [XLEN-1:0]   iadder_in,
  input  logic [XLEN-1:0]   pc_plus_4_in,
  input  logic [XLEN-1:0]   csr_data_in,
  input  logic [XLEN-1:0]   load_data_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic [1:0]        addr_lsb_in,
  input  logic [RA_W-1:0]   rd_addr_in,
  input  logic              rf_wr_en_in,
  input  logic              rf_ready_in,
  output logic              valid_out,
  output logic              rf_wr_en_out,
  output logic [RA_W-1:0]   rd_addr_out,
  output logic [XLEN-1:0]   rd_data_out,
  output logic              misalign_err_out,
  output logic [CNT_W-1:0]  instret_out
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [RA_W-1:0] rd;
    logic            wr_en;
    logic            mis;
  } entry_t;

  entry_t            or_q, or_d, sk_q, sk_d, new_entry;
  logic              or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [XLEN-1:0]   shifted, ld_ext, sel_data;
  logic              is_load, mis, accept, retire;

  assign shifted = load_data_in >> {addr_lsb_in, 3'b000};
  assign is_load = (wb_mux_sel_in == 3'b001);
  assign mis     = is_load &&
                   (((load_size_in == 2'b01) && addr_lsb_in[0]) ||
                    (load_size_in[1] && (addr_lsb_in != 2'b00)));

  // Fill with the sign bit first, then overlay the extracted field.
  always_comb begin
    ld_ext = shifted;
    case (load_size_in)
      2'b00: begin
        ld_ext      = {XLEN{~load_unsigned_in & shifted[7]}};
        ld_ext[7:0] = shifted[7:0];
      end
      2'b01: begin
        ld_ext       = {XLEN{~load_unsigned_in & shifted[15]}};
        ld_ext[15:0] = shifted[15:0];
      end
      2'b10: begin
        ld_ext       = {XLEN{~load_unsigned_in & shifted[31]}};
        ld_ext[31:0] = shifted[31:0];
      end
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    case (wb_mux_sel_in)
      3'b001:  sel_data = mis ? '0 : ld_ext;
      3'b010:  sel_data = imm_in;
      3'b011:  sel_data = iadder_in;
      3'b100:  sel_data = csr_data_in;
      3'b101:  sel_data = pc_plus_4_in;
      default: sel_data = alu_result_in;
    endcase
  end

  assign new_entry = '{data: sel_data, rd: rd_addr_in, wr_en: rf_wr_en_in, mis: mis};
  assign accept    = valid_in & ready_out;
  assign retire    = or_vld_q & rf_ready_in;

  // Accept while the skid is full cannot happen, so a skid drain never collides with new data.
  always_comb begin
    or_d      = or_q;
    sk_d      = sk_q;
    or_vld_d  = or_vld_q;
    sk_vld_d  = sk_vld_q;
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + 1'b1;
      if (sk_vld_q) begin
        or_d     = sk_q;
        sk_vld_d = 1'b0;
      end else if (accept) begin
        or_d = new_entry;
      end else begin
        or_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!or_vld_q) begin
        or_d     = new_entry;
        or_vld_d = 1'b1;
      end else begin
        sk_d     = new_entry;
        sk_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      or_q      <= '0;
      sk_q      <= '0;
      or_vld_q  <= 1'b0;
      sk_vld_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      or_q      <= or_d;
      sk_q      <= sk_d;
      or_vld_q  <= or_vld_d;
      sk_vld_q  <= sk_vld_d;
      instret_q <= instret_d;
    end
  end

  assign ready_out        = ~sk_vld_q;
  assign valid_out        = or_vld_q;
  assign rd_addr_out      = or_q.rd;
  assign rd_data_out      = or_q.data;
  assign rf_wr_en_out     = or_vld_q & or_q.wr_en & (or_q.rd != '0) & ~or_q.mis;
  assign misalign_err_out = retire & or_q.mis;
  assign instret_out      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scoreboard of expected writebacks, compared as entries retire.
module tb_wb_stage;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  wb_mux_sel_in;
  logic [31:0] alu_result_in, imm_in, iadder_in, pc_plus_4_in, csr_data_in, load_data_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  addr_lsb_in;
  logic [4:0]  rd_addr_in;
  logic        rf_wr_en_in;
  logic        rf_ready_in;
  logic        valid_out;
  logic        rf_wr_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        misalign_err_out;
  logic [63:0] instret_out;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] alu, imm, iadder, pc4, csr, ld;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lsb;
    logic [4:0]  rd;
    logic        wr;
  } stim_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  longint unsigned ret_cnt = 0;
  logic        sends_done;

  wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .wb_mux_sel_in(wb_mux_sel_in), .alu_result_in(alu_result_in), .imm_in(imm_in),
    .iadder_in(iadder_in), .pc_plus_4_in(pc_plus_4_in), .csr_data_in(csr_data_in),
    .load_data_in(load_data_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .addr_lsb_in(addr_lsb_in),
    .rd_addr_in(rd_addr_in), .rf_wr_en_in(rf_wr_en_in), .rf_ready_in(rf_ready_in),
    .valid_out(valid_out), .rf_wr_en_out(rf_wr_en_out), .rd_addr_out(rd_addr_out),
    .rd_data_out(rd_data_out), .misalign_err_out(misalign_err_out),
    .instret_out(instret_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [7:0]  b;
    logic [15:0] h;
    e.mis  = 1'b0;
    e.rd   = s.rd;
    case (s.sel)
      3'd1: begin
        if (s.size == 2'b00) begin
          b = s.ld[s.lsb*8 +: 8];
          e.data = s.uns ? {24'h0, b} : {{24{b[7]}}, b};
        end else if (s.size == 2'b01) begin
          if (s.lsb == 2'd1 || s.lsb == 2'd3) begin
            e.mis  = 1'b1;
            e.data = 32'h0;
          end else begin
            h = (s.lsb == 2'd2) ? s.ld[31:16] : s.ld[15:0];
            e.data = s.uns ? {16'h0, h} : {{16{h[15]}}, h};
          end
        end else begin
          e.mis  = (s.lsb != 2'd0);
          e.data = e.mis ? 32'h0 : s.ld;
        end
      end
      3'd2:    e.data = s.imm;
      3'd3:    e.data = s.iadder;
      3'd4:    e.data = s.csr;
      3'd5:    e.data = s.pc4;
      default: e.data = s.alu;
    endcase
    e.wr = s.wr && (s.rd != 5'd0) && !e.mis;
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sel = 3'($urandom_range(0, 7));
    s.alu = $urandom; s.imm = $urandom; s.iadder = $urandom;
    s.pc4 = $urandom; s.csr = $urandom; s.ld = $urandom;
    s.size = 2'($urandom_range(0, 3));
    s.uns  = 1'($urandom_range(0, 1));
    s.lsb  = 2'($urandom_range(0, 3));
    s.rd   = 5'($urandom_range(0, 31));
    s.wr   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Present one entry and hold it until the stage takes it.
  task automatic send(input stim_t s);
    int n = 0;
    wb_mux_sel_in = s.sel; alu_result_in = s.alu; imm_in = s.imm; iadder_in = s.iadder;
    pc_plus_4_in = s.pc4; csr_data_in = s.csr; load_data_in = s.ld; load_size_in = s.size;
    load_unsigned_in = s.uns; addr_lsb_in = s.lsb; rd_addr_in = s.rd; rf_wr_en_in = s.wr;
    valid_in = 1'b1;
    forever begin
      @(negedge clk_in);
      if (ready_out) begin
        sb.push_back(model(s));
        break;
      end
      n++;
      if (n > 50) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk_in); #1;
    chk("drain_valid", 64'(valid_out), 64'd0);
    chk("drain_instret", instret_out, ret_cnt);
  endtask

  // Retire monitor: sampled on the falling edge, away from the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && valid_out && rf_ready_in) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rd_data", 64'(rd_data_out), 64'(e.data));
          chk("rd_addr", 64'(rd_addr_out), 64'(e.rd));
          chk("rf_wr_en", 64'(rf_wr_en_out), 64'(e.wr));
          chk("misalign", 64'(misalign_err_out), 64'(e.mis));
          chk("instret", instret_out, ret_cnt);
          ret_cnt++;
        end
      end else if (rst_n_in) begin
        chk("misalign_idle", 64'(misalign_err_out), 64'd0);
      end
    end
  end

  initial begin
    stim_t s;
    valid_in = 1'b0; rf_ready_in = 1'b1; sends_done = 1'b0;
    wb_mux_sel_in = '0; alu_result_in = '0; imm_in = '0; iadder_in = '0;
    pc_plus_4_in = '0; csr_data_in = '0; load_data_in = '0; load_size_in = '0;
    load_unsigned_in = 1'b0; addr_lsb_in = '0; rd_addr_in = '0; rf_wr_en_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_instret", instret_out, 64'd0);
    chk("rst_data", 64'(rd_data_out), 64'd0);
    repeat (2) @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Single ALU op
    s = rand_stim(); s.sel = 3'b000; s.alu = 32'h0000_1234; s.rd = 5'd5; s.wr = 1'b1;
    send(s);
    drain();

    // Signed and unsigned byte load from the top byte lane
    s = rand_stim(); s.sel = 3'b001; s.ld = 32'h80FF_7F01; s.lsb = 2'd3; s.size = 2'b00;
    s.uns = 1'b0; s.rd = 5'd9; s.wr = 1'b1;
    send(s);
    s.uns = 1'b1;
    send(s);
    // Misaligned half
    s = rand_stim(); s.sel = 3'b001; s.lsb = 2'd1; s.size = 2'b01; s.rd = 5'd7; s.wr = 1'b1;
    send(s);
    // Write to x0 is suppressed but still retires
    s = rand_stim(); s.sel = 3'b101; s.pc4 = 32'h0000_0104; s.rd = 5'd0; s.wr = 1'b1;
    send(s);
    drain();

    // Backpressure: A in OR, B in skid, C waits
    rf_ready_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          s = rand_stim(); s.sel = 3'b000; s.alu = 32'hA000_0000 + i; s.rd = 5'(10 + i); s.wr = 1'b1;
          send(s);
        end
      end
      begin
        repeat (3) @(negedge clk_in);
        chk("bp_ready", 64'(ready_out), 64'd0);
        chk("bp_valid", 64'(valid_out), 64'd1);
        chk("bp_or_data", 64'(rd_data_out), 64'hA000_0000);
        @(posedge clk_in); #1;
        rf_ready_in = 1'b1;
      end
    join
    drain();

    // Random traffic with a toggling register-file port
    fork
      begin
        for (int i = 0; i < 60; i++) send(rand_stim());
        sends_done = 1'b1;
      end
      begin
        while (!sends_done) begin
          @(posedge clk_in); #1;
          rf_ready_in = 1'($urandom_range(0, 1));
        end
      end
    join
    rf_ready_in = 1'b1;
    drain();

    // Reset with both OR and skid occupied
    rf_ready_in = 1'b0;
    s = rand_stim(); s.sel = 3'b001; s.size = 2'b10; s.lsb = 2'd2; s.rd = 5'd3; s.wr = 1'b1;
    send(s);
    s = rand_stim(); s.sel = 3'b010; s.rd = 5'd4; s.wr = 1'b1;
    send(s);
    chk("pre_rst_ready", 64'(ready_out), 64'd0);
    #1 rst_n_in = 1'b0;
    rf_ready_in = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_wr_en", 64'(rf_wr_en_out), 64'd0);
    chk("mid_rst_rd", 64'(rd_addr_out), 64'd0);
    chk("mid_rst_data", 64'(rd_data_out), 64'd0);
    chk("mid_rst_misalign", 64'(misalign_err_out), 64'd0);
    chk("mid_rst_instret", instret_out, 64'd0);
    chk("mid_rst_ready", 64'(ready_out), 64'd1);
    sb.delete();
    ret_cnt = 0;
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    s = rand_stim(); s.sel = 3'b100; s.rd = 5'd31; s.wr = 1'b1;
    send(s);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
